add_accum_pipe: RTL
===================

ADD_ACCUM_PIPE -- requirements
Module: add_accum_pipe

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32: width of operand A (1..64).
REQ-002 SHALL have parameter B_WIDTH, default 32: width of operand B (1..64).
REQ-003 SHALL have parameter Y_WIDTH, default 32: width of result Y (1..64).
REQ-004 SHALL have parameter A_SIGNED, default 0: 1 = A sign-extended, 0 = zero-extended.
REQ-005 SHALL have parameter B_SIGNED, default 0: as A_SIGNED for B.
REQ-006 SHALL have parameter STAGES, default 2: pipeline depth (1..4); other values rejected at elaboration.
REQ-007 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-008 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port in_valid  input  1  operand beat offered.
REQ-010 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-011 SHALL have port op  input  2  00 add, 01 sub (A-B), 10 accumulate (acc+A), 11 load (acc:=A).
REQ-012 SHALL have ports A  input  A_WIDTH  and  B  input  B_WIDTH  operands.
REQ-013 SHALL have port out_valid  output  1  result beat present.
REQ-014 SHALL have port out_ready  input  1  consumer takes beat when out_valid && out_ready.
REQ-015 SHALL have ports Y  output  Y_WIDTH  result;  C_out  output  1  carry/borrow;  OVF  output  1  overflow.

Function
REQ-016 Internal width W = max(A_WIDTH, B_WIDTH, Y_WIDTH) + 1; A, B, accumulator extended to W per A_SIGNED/B_SIGNED (accumulator uses A_SIGNED).
REQ-017 Signed mode = A_SIGNED && B_SIGNED; any other combination = unsigned mode.
REQ-018 Accumulator acc, W-1 bits wide internally, truncated to Y_WIDTH on output.
REQ-019 Compute in stage 1 on acceptance; stages 2..STAGES are pure delay registers carrying {valid, Y, C_out, OVF}.
REQ-020 Global advance enable en = out_ready || !out_valid; in_ready = en (combinational, no dependence on in_valid).
REQ-021 When en = 0 every stage SHALL hold; no beat dropped or duplicated; Y, C_out, OVF stable while out_valid && !out_ready.
REQ-022 Latency: accepted beat appears on out_valid exactly STAGES cycles later when out_ready held 1; throughput one beat/cycle.
REQ-023 Bubbles (in_valid = 0 while en = 1) propagate as invalid stages; empty stages never assert out_valid.
REQ-024 op 00: R = A + B; op 01: R = A - B; op 10: R = acc + A, acc := R; op 11: R = A, acc := A.
REQ-025 acc SHALL update only on an accepted beat with op 10/11; ops 00/01 leave acc unchanged.
REQ-026 Back-to-back accumulate beats SHALL each see the acc produced by the previous accepted beat (no hazard).
REQ-027 Y = R[Y_WIDTH-1:0]; C_out = R[Y_WIDTH] (unsigned carry-out for add/acc, borrow for sub, 0 for load).
REQ-028 OVF unsigned mode: R does not fit in Y_WIDTH unsigned bits (carry or borrow); signed mode: R outside [-2^(Y_WIDTH-1), 2^(Y_WIDTH-1)-1]; load: 0.
REQ-029 Overflowed accumulate wraps acc modulo 2^Y_WIDTH; no saturation.

Reset
REQ-030 While RST = 1: all stage valids 0, acc 0, Y 0, C_out 0, OVF 0, out_valid 0; in_ready = 1.
REQ-031 RST asserted mid-stream SHALL discard all in-flight beats; beat offered in the RST cycle not accepted.
REQ-032 First beat accepted in the cycle after RST deasserts.

Verification
REQ-033 Defaults, out_ready = 1: beat A=5, B=7, op 00 at cycle 0 -> out_valid at cycle 2, Y=12, C_out=0, OVF=0.
REQ-034 Unsigned, W=32: A=32'hFFFFFFFF, B=1, op 00 -> Y=0, C_out=1, OVF=1; op 01 A=3, B=5 -> Y=32'hFFFFFFFE, C_out=1, OVF=1.
REQ-035 A_SIGNED=B_SIGNED=1, Y_WIDTH=8: A=8'h7F, B=1, op 00 -> Y=8'h80, OVF=1; A=8'hFF (-1), B=1 -> Y=0, OVF=0.
REQ-036 Accumulate: op 11 A=10, then op 10 A=1,2,3 back-to-back -> Y sequence 10, 11, 13, 16; acc=16.
REQ-037 Backpressure STAGES=3: 5 beats streamed, out_ready low cycles 3..6 -> in_ready low those cycles, all 5 results delivered in order, Y stable while stalled.
REQ-038 RST pulsed with 2 beats in flight -> out_valid 0 next cycle, acc 0, no stale beat ever emitted.

Source files
------------

// File: rtl/add_accum_pipe.sv
// add_accum_pipe: add/sub/accumulate/load unit with a valid/ready
// pipeline; compute in stage 1, later stages only delay the result.
module add_accum_pipe #(
  parameter int A_WIDTH  = 32,
  parameter int B_WIDTH  = 32,
  parameter int Y_WIDTH  = 32,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0,
  parameter int STAGES   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] Y,
  output logic               C_out,
  output logic               OVF
);

  localparam int AB = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int W  = ((AB > Y_WIDTH) ? AB : Y_WIDTH) + 1;
  localparam bit AS = (A_SIGNED != 0);
  localparam bit BS = (B_SIGNED != 0);
  localparam bit SM = AS && BS;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("add_accum_pipe: STAGES must be 1..4");
  end
  if (A_WIDTH < 1 || A_WIDTH > 64 || B_WIDTH < 1 || B_WIDTH > 64 ||
      Y_WIDTH < 1 || Y_WIDTH > 64) begin : g_bad_width
    $error("add_accum_pipe: widths must be 1..64");
  end

  logic [W-2:0] acc;
  logic [W-2:0] acc_n;
  logic [W-1:0] a_x;
  logic [W-1:0] b_x;
  logic [W-1:0] acc_x;
  logic [W-1:0] r;
  logic [W-Y_WIDTH:0] hi;
  logic         a_s;
  logic         b_s;
  logic         acc_s;
  logic         c;
  logic         ovf;
  logic         en;
  logic         take;

  assign a_s   = AS & A[A_WIDTH-1];
  assign b_s   = BS & B[B_WIDTH-1];
  assign acc_s = AS & acc[W-2];
  assign a_x   = {{(W-A_WIDTH){a_s}}, A};
  assign b_x   = {{(W-B_WIDTH){b_s}}, B};
  assign acc_x = {acc_s, acc};
  assign hi    = r[W-1:Y_WIDTH-1];

  always_comb begin
    r     = '0;
    acc_n = acc;
    unique case (op)
      2'b00: r = a_x + b_x;
      2'b01: r = a_x - b_x;
      2'b10: r = acc_x + a_x;
      2'b11: r = a_x;
    endcase
    if (SM) begin
      ovf = !((&hi) || !(|hi));
    end else begin
      ovf = |hi[W-Y_WIDTH:1];
    end
    c = r[Y_WIDTH];
    if (op == 2'b11) begin
      c     = 1'b0;
      ovf   = 1'b0;
      acc_n = a_x[W-2:0];
    end
    // accumulate wraps at the result width, not the internal width
    if (op == 2'b10) begin
      if (AS) begin
        acc_n = (W-1)'($signed(r[Y_WIDTH-1:0]));
      end else begin
        acc_n = (W-1)'(r[Y_WIDTH-1:0]);
      end
    end
  end

  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  c_q;
  logic [STAGES-1:0]  o_q;
  logic [Y_WIDTH-1:0] y_q [STAGES];

  assign en       = out_ready || !out_valid;
  assign in_ready = en;
  assign take     = in_valid && en && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld <= '0;
      c_q <= '0;
      o_q <= '0;
      acc <= '0;
      for (int i = 0; i < STAGES; i++) begin
        y_q[i] <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      y_q[0] <= r[Y_WIDTH-1:0];
      c_q[0] <= c;
      o_q[0] <= ovf;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        y_q[i] <= y_q[i-1];
        c_q[i] <= c_q[i-1];
        o_q[i] <= o_q[i-1];
      end
      if (take && op[1]) begin
        acc <= acc_n;
      end
    end
  end

  // reset masks the outputs in the same cycle it is asserted
  assign out_valid = vld[STAGES-1] && !RST;
  assign Y         = RST ? '0 : y_q[STAGES-1];
  assign C_out     = c_q[STAGES-1] && !RST;
  assign OVF       = o_q[STAGES-1] && !RST;

endmodule
